// File: rtl/sumador_serie.sv
// rtl/sumador_serie.sv - bit-serial N-bit adder, LSB first, start/busy/done handshake
module sumador_serie #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic          r_carry;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_sum;
  logic          r_cout;

  logic          w_s1;
  logic          w_c1;
  logic          w_s2;
  logic          w_c2;
  logic          w_load;
  logic          w_run;
  logic          w_last;
  logic [N-1:0]  w_pr_final;

  // Full-adder step: HA1 on the operand bits, HA2 folds in the stored carry.
  assign w_s1 = r_sa[0] ^ r_sb[0];
  assign w_c1 = r_sa[0] & r_sb[0];
  assign w_s2 = w_s1 ^ r_carry;
  assign w_c2 = w_s1 & r_carry;

  // A start is honoured only when no add is in flight.
  assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_run  = (r_state == S_RUN);
  assign w_last = w_run && (r_cnt == LAST);

  // The partial register keeps the N-1 bits finished before the last step;
  // the last step's s2 is appended directly so the result is ready on the
  // completing edge without an extra shift cycle.
  generate
    if (N == 1) begin : g_pr1
      assign w_pr_final = w_s2;
    end else if (N == 2) begin : g_pr2
      logic r_pr;
      // Single partial bit for the two-bit case.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pr <= 1'b0;
        end else if (w_run) begin
          r_pr <= w_s2;
        end
      end
      assign w_pr_final = {w_s2, r_pr};
    end else begin : g_prn
      logic [N-2:0] r_pr;
      // New sum bits enter at the MSB and drift toward the LSB.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pr <= '0;
        end else if (w_run) begin
          r_pr <= {w_s2, r_pr[N-2:1]};
        end
      end
      assign w_pr_final = {w_s2, r_pr};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: DONE may chain straight into RUN for back-to-back adds.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand shifters, carry flip-flop and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_sa    <= a;
      r_sb    <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_sa    <= r_sa >> 1;
      r_sb    <= r_sb >> 1;
      r_carry <= w_c1 | w_c2;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Result registers change only on the completing edge, so partial bits never show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_pr_final;
      r_cout <= w_c1 | w_c2;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_sumador_serie.sv
// tb/tb_sumador_serie.sv - self-checking bench for sumador_serie
module tb_sumador_serie;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;

  int n_chk  = 0;
  int n_fail = 0;

  sumador_serie #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One isolated add: start for one cycle, then watch latency, busy length and result hold.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        output logic [7:0] rs, output logic rc, output int lat,
                        output int nbusy, output logic hold_ok);
    logic [7:0] prev_s;
    logic       prev_c;
    @(negedge clk);
    prev_s = sum;
    prev_c = cout;
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 1; nbusy = 0; hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (sum !== prev_s || cout !== prev_c) hold_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    rs = sum;
    rc = cout;
  endtask

  vec_t       vecs [7];
  logic [7:0] rs;
  logic       rc;
  int         lat;
  int         nbusy;
  logic       hold_ok;
  logic       seen;
  logic [8:0] q [$];
  logic [8:0] expv;
  int         issued;
  int         ndone;
  int         cyc;
  int         last_done;

  initial begin
    vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, s: 8'h8D, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, co: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, s: 8'h80, co: 1'b0};
    vecs[6] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table-driven single adds.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, nbusy, hold_ok);
      check($sformatf("vec%0d_sum", i),  32'(rs),      32'(vecs[i].s));
      check($sformatf("vec%0d_cout", i), 32'(rc),      32'(vecs[i].co));
      check($sformatf("vec%0d_lat", i),  32'(lat),     32'(N + 1));
      check($sformatf("vec%0d_busy", i), 32'(nbusy),   32'(N));
      check($sformatf("vec%0d_hold", i), 32'(hold_ok), 32'd1);
    end

    // start held through RUN with operands churning, then a back-to-back add from DONE.
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
    end while (!done && lat < 40);
    check("held_lat",  32'(lat),  32'(N + 1));
    check("held_sum",  32'(sum),  32'h8D);
    check("held_cout", 32'(cout), 32'd0);
    a = 8'h01; b = 8'h02; cin = 1'b0;
    @(negedge clk);
    check("b2b_no_idle", 32'(busy), 32'd1);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat",  32'(lat),  32'(N + 1));
    check("b2b_sum",  32'(sum),  32'h03);
    check("b2b_cout", 32'(cout), 32'd0);

    // Abort mid-RUN with an asynchronous reset, between clock edges.
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, rs, rc, lat, nbusy, hold_ok);
    check("post_abort_sum",  32'(rs), 32'h30);
    check("post_abort_cout", 32'(rc), 32'd0);

    // Random back-to-back adds against a plain arithmetic model.
    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); start = 1'b1;
    q.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
    issued = 1; ndone = 0; cyc = 0; last_done = -1;
    while (ndone < 200 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        expv = q.pop_front();
        check("rand_result", 32'({cout, sum}), 32'(expv));
        if (last_done >= 0) check("rand_spacing", 32'(cyc - last_done), 32'(N + 1));
        last_done = cyc;
        ndone++;
        if (issued < 200) begin
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
          q.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
          issued++;
        end else begin
          start = 1'b0;
        end
      end
    end
    check("rand_count", 32'(ndone), 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
